// File: rtl/regs_pkg.sv
// Shared defaults and read-port field layout for the rename register file.
// rdata per port is {data, busy, tag}, MSB first.
package regs_pkg;

  localparam int unsigned NREGS_DEF  = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ROB_W_DEF  = 6;
  localparam int unsigned N_RD_DEF   = 8;
  localparam int unsigned N_AL_DEF   = 4;
  localparam int unsigned N_WB_DEF   = 2;

  localparam int unsigned RD_TAG_LSB = 0;

  function automatic int unsigned rd_busy_bit(input int unsigned rob_w);
    return rob_w;
  endfunction

  function automatic int unsigned rd_data_lsb(input int unsigned rob_w);
    return rob_w + 1;
  endfunction

  function automatic int unsigned rd_width(input int unsigned data_w, input int unsigned rob_w);
    return data_w + 1 + rob_w;
  endfunction

endpackage

// File: rtl/regs_entry.sv
// One architectural register: data, busy bit and rename tag, with the
// allocate/commit/flush priority resolution for that register.
module regs_entry
  import regs_pkg::*;
#(
  parameter int unsigned IDX    = 0,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ROB_W  = ROB_W_DEF,
  parameter int unsigned AW     = 3,
  parameter int unsigned N_AL   = N_AL_DEF,
  parameter int unsigned N_WB   = N_WB_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [N_AL-1:0]          al_en,
  input  logic [N_AL*AW-1:0]       al_addr,
  input  logic [N_AL*ROB_W-1:0]    al_tag,
  input  logic [N_WB-1:0]          wb_en,
  input  logic [N_WB*AW-1:0]       wb_addr,
  input  logic [N_WB*ROB_W-1:0]    wb_tag,
  input  logic [N_WB*DATA_W-1:0]   wb_data,
  output logic [DATA_W-1:0]        data_o,
  output logic                     busy_o,
  output logic [ROB_W-1:0]         tag_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic [ROB_W-1:0]  tag_q, tag_d;
  logic              al_hit;
  logic [ROB_W-1:0]  al_tag_sel;
  logic              wb_match;

  // Later ports override earlier ones: highest index is youngest.
  always_comb begin
    data_d     = data_q;
    busy_d     = busy_q;
    tag_d      = tag_q;
    al_hit     = 1'b0;
    al_tag_sel = '0;
    wb_match   = 1'b0;

    for (int i = 0; i < int'(N_AL); i++) begin
      if (al_en[i] && (al_addr[i*AW +: AW] == AW'(IDX))) begin
        al_hit     = 1'b1;
        al_tag_sel = al_tag[i*ROB_W +: ROB_W];
      end
    end

    for (int j = 0; j < int'(N_WB); j++) begin
      if (wb_en[j] && (wb_addr[j*AW +: AW] == AW'(IDX))) begin
        data_d = wb_data[j*DATA_W +: DATA_W];
        if (wb_tag[j*ROB_W +: ROB_W] == tag_q) begin
          wb_match = 1'b1;
        end
      end
    end

    // Flush discards allocates; a fresh allocate outranks a commit's busy clear.
    if (flush) begin
      busy_d = 1'b0;
    end else if (al_hit) begin
      busy_d = 1'b1;
      tag_d  = al_tag_sel;
    end else if (wb_match) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;
  assign tag_o  = tag_q;

endmodule

// File: rtl/regs_rename.sv
// Register file with rename busy/tag tracking: multi-port allocate, in-order
// commit write-back, flush, and registered-address read ports.
module regs_rename
  import regs_pkg::*;
#(
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned ROB_W  = ROB_W_DEF,
  parameter  int unsigned N_RD   = N_RD_DEF,
  parameter  int unsigned N_AL   = N_AL_DEF,
  parameter  int unsigned N_WB   = N_WB_DEF,
  localparam int unsigned AW     = $clog2(NREGS),
  localparam int unsigned RW     = DATA_W + 1 + ROB_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_RD*AW-1:0]     raddr,
  output logic [N_RD*RW-1:0]     rdata,
  input  logic [N_AL-1:0]        al_en,
  input  logic [N_AL*AW-1:0]     al_addr,
  input  logic [N_AL*ROB_W-1:0]  al_tag,
  input  logic [N_WB-1:0]        wb_en,
  input  logic [N_WB*AW-1:0]     wb_addr,
  input  logic [N_WB*ROB_W-1:0]  wb_tag,
  input  logic [N_WB*DATA_W-1:0] wb_data,
  input  logic                   flush,
  output logic [NREGS-1:0]       busy_vec
);

  localparam int unsigned BUSY_OFS = rd_busy_bit(ROB_W);
  localparam int unsigned DATA_OFS = rd_data_lsb(ROB_W);

  logic [NREGS-1:0][DATA_W-1:0] data_all;
  logic [NREGS-1:0]             busy_all;
  logic [NREGS-1:0][ROB_W-1:0]  tag_all;
  logic [N_RD*AW-1:0]           raddr_q, raddr_d;
  logic [AW-1:0]                rd_idx;

  for (genvar r = 0; r < int'(NREGS); r++) begin : g_entry
    regs_entry #(
      .IDX    (r),
      .DATA_W (DATA_W),
      .ROB_W  (ROB_W),
      .AW     (AW),
      .N_AL   (N_AL),
      .N_WB   (N_WB)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .al_en   (al_en),
      .al_addr (al_addr),
      .al_tag  (al_tag),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_tag  (wb_tag),
      .wb_data (wb_data),
      .data_o  (data_all[r]),
      .busy_o  (busy_all[r]),
      .tag_o   (tag_all[r])
    );
  end

  always_comb begin
    raddr_d = raddr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
    end else begin
      raddr_q <= raddr_d;
    end
  end

  // Read ports see the state written on the same edge that captured the address.
  always_comb begin
    rdata  = '0;
    rd_idx = '0;
    for (int k = 0; k < int'(N_RD); k++) begin
      rd_idx = raddr_q[k*AW +: AW];
      rdata[k*RW + RD_TAG_LSB +: ROB_W] = tag_all[rd_idx];
      rdata[k*RW + BUSY_OFS]            = busy_all[rd_idx];
      rdata[k*RW + DATA_OFS +: DATA_W]  = data_all[rd_idx];
    end
  end

  assign busy_vec = busy_all;

endmodule
